// File: rtl/battle_pkg.sv
// Shared definitions for the team-select and battle blocks: keycodes, roster
// sizing, the pokemon ID type and the team-select state encoding.
package battle_pkg;

    localparam int ROSTER_SIZE = 8;
    localparam int TEAM_SIZE   = 2;
    localparam int ROW_LEN     = 4;
    localparam int MON_W       = 3;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_BKSP  = 8'h2A;

    typedef logic [MON_W-1:0] mon_id_t;

    typedef enum logic [2:0] {
        ST_TITLE     = 3'd0,
        ST_PICK      = 3'd1,
        ST_READY     = 3'd2,
        ST_LAUNCH    = 3'd3,
        ST_IN_BATTLE = 3'd4,
        ST_REPORT    = 3'd5
    } team_state_t;

    // Win/loss counters stick at 15 rather than wrapping back to zero.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        if (v == 4'd15) begin
            return v;
        end else begin
            return v + 4'd1;
        end
    endfunction

endpackage

// File: rtl/key_edge.sv
// Keypress edge detector: a key acts only on the first cycle it differs from
// the previously sampled keycode, so a held key produces a single press.
module key_edge (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] keycode_i,
    output logic       press_o,
    output logic [7:0] key_o
);

    logic [7:0] prev_key_q;
    logic [7:0] prev_key_d;

    // Next value of the previous-key register is simply the current keycode.
    always_comb begin
        prev_key_d = keycode_i;
    end

    // Previous-key register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_key_q <= 8'h00;
        end else begin
            prev_key_q <= prev_key_d;
        end
    end

    assign press_o = (keycode_i != 8'h00) && (keycode_i != prev_key_q);
    assign key_o   = keycode_i;

endmodule

// File: rtl/team_select.sv
// Team selection front end for the battle FSM: roster cursor, distinct picks,
// battle launch and win/loss bookkeeping. Define TEAM_SELECT_UNDO_EN to let
// BKSP remove the most recent pick.
module team_select
    import battle_pkg::*;
(
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [7:0]                keycode,
    input  logic                      end_battle,
    input  logic                      result,
    output logic [TEAM_SIZE*MON_W-1:0] team,
    output logic                      is_battle,
    output logic [MON_W-1:0]          cursor,
    output logic [ROSTER_SIZE-1:0]    picked_mask,
    output logic [1:0]                pick_count,
    output logic [3:0]                wins,
    output logic [3:0]                losses
);

    localparam int TEAM_W = TEAM_SIZE * MON_W;

    logic       press_s;
    logic [7:0] key_s;

    team_state_t             state_q, state_d;
    logic [TEAM_W-1:0]       team_q, team_d;
    logic                    is_battle_q, is_battle_d;
    mon_id_t                 cursor_q, cursor_d;
    logic [ROSTER_SIZE-1:0]  picked_mask_q, picked_mask_d;
    logic [1:0]              pick_count_q, pick_count_d;
    logic [3:0]              wins_q, wins_d;
    logic [3:0]              losses_q, losses_d;
`ifdef TEAM_SELECT_UNDO_EN
    logic                    undo_s;
    logic [1:0]              last_idx_s;
`endif

    key_edge u_key_edge (
        .clk_i     (Clk),
        .reset_i   (Reset),
        .keycode_i (keycode),
        .press_o   (press_s),
        .key_o     (key_s)
    );

    // Next-state and output logic for the selection/battle flow.
    always_comb begin
        state_d       = state_q;
        team_d        = team_q;
        is_battle_d   = is_battle_q;
        cursor_d      = cursor_q;
        picked_mask_d = picked_mask_q;
        pick_count_d  = pick_count_q;
        wins_d        = wins_q;
        losses_d      = losses_q;
`ifdef TEAM_SELECT_UNDO_EN
        undo_s        = 1'b0;
        last_idx_s    = pick_count_q - 2'd1;
`endif

        case (state_q)
            ST_TITLE: begin
                if (press_s && (key_s == KEY_ENTER)) begin
                    state_d       = ST_PICK;
                    pick_count_d  = 2'd0;
                    picked_mask_d = {ROSTER_SIZE{1'b0}};
                    team_d        = {TEAM_W{1'b0}};
                end else begin
                    state_d = ST_TITLE;
                end
            end

            ST_PICK: begin
                if (press_s) begin
                    case (key_s)
                        KEY_A: begin
                            if ((cursor_q % 3'(ROW_LEN)) != 3'd0) begin
                                cursor_d = cursor_q - 3'd1;
                            end else begin
                                cursor_d = cursor_q;
                            end
                        end
                        KEY_D: begin
                            if ((cursor_q % 3'(ROW_LEN)) != 3'(ROW_LEN - 1)) begin
                                cursor_d = cursor_q + 3'd1;
                            end else begin
                                cursor_d = cursor_q;
                            end
                        end
                        KEY_W: begin
                            if (cursor_q >= 3'(ROW_LEN)) begin
                                cursor_d = cursor_q - 3'(ROW_LEN);
                            end else begin
                                cursor_d = cursor_q;
                            end
                        end
                        KEY_S: begin
                            if (cursor_q < 3'(ROW_LEN)) begin
                                cursor_d = cursor_q + 3'(ROW_LEN);
                            end else begin
                                cursor_d = cursor_q;
                            end
                        end
                        KEY_ENTER: begin
                            // Already-picked IDs are rejected so the team stays distinct.
                            if (!picked_mask_q[cursor_q]) begin
                                for (int i = 0; i < TEAM_SIZE; i++) begin
                                    if (pick_count_q == 2'(i)) begin
                                        team_d[i*MON_W +: MON_W] = cursor_q;
                                    end else begin
                                        team_d[i*MON_W +: MON_W] = team_q[i*MON_W +: MON_W];
                                    end
                                end
                                picked_mask_d[cursor_q] = 1'b1;
                                pick_count_d            = pick_count_q + 2'd1;
                                if (pick_count_q == 2'(TEAM_SIZE - 1)) begin
                                    state_d = ST_READY;
                                end else begin
                                    state_d = ST_PICK;
                                end
                            end else begin
                                state_d = ST_PICK;
                            end
                        end
`ifdef TEAM_SELECT_UNDO_EN
                        KEY_BKSP: begin
                            undo_s = (pick_count_q != 2'd0);
                        end
`endif
                        default: begin
                            state_d = ST_PICK;
                        end
                    endcase
                end else begin
                    state_d = ST_PICK;
                end
            end

            ST_READY: begin
                if (press_s && (key_s == KEY_ENTER)) begin
                    state_d = ST_LAUNCH;
`ifdef TEAM_SELECT_UNDO_EN
                end else if (press_s && (key_s == KEY_BKSP)) begin
                    undo_s = (pick_count_q != 2'd0);
`endif
                end else begin
                    state_d = ST_READY;
                end
            end

            ST_LAUNCH: begin
                state_d     = ST_IN_BATTLE;
                is_battle_d = 1'b1;
            end

            ST_IN_BATTLE: begin
                // Keys are ignored here, including one arriving with end_battle.
                if (end_battle) begin
                    is_battle_d = 1'b0;
                    state_d     = ST_REPORT;
                    if (result) begin
                        wins_d = sat_inc4(wins_q);
                    end else begin
                        losses_d = sat_inc4(losses_q);
                    end
                end else begin
                    is_battle_d = 1'b1;
                end
            end

            ST_REPORT: begin
                if (press_s && (key_s == KEY_ENTER)) begin
                    state_d       = ST_PICK;
                    pick_count_d  = 2'd0;
                    picked_mask_d = {ROSTER_SIZE{1'b0}};
                    team_d        = {TEAM_W{1'b0}};
                end else begin
                    state_d = ST_REPORT;
                end
            end

            default: begin
                state_d     = ST_TITLE;
                is_battle_d = 1'b0;
            end
        endcase

`ifdef TEAM_SELECT_UNDO_EN
        // Undo pops the newest slot and frees its ID for picking again.
        if (undo_s) begin
            for (int i = 0; i < TEAM_SIZE; i++) begin
                if (last_idx_s == 2'(i)) begin
                    picked_mask_d[team_q[i*MON_W +: MON_W]] = 1'b0;
                    team_d[i*MON_W +: MON_W]                = 3'd0;
                end else begin
                    team_d[i*MON_W +: MON_W] = team_q[i*MON_W +: MON_W];
                end
            end
            pick_count_d = last_idx_s;
            state_d      = ST_PICK;
        end else begin
            pick_count_d = pick_count_d;
        end
`endif
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_TITLE;
            team_q        <= {TEAM_W{1'b0}};
            is_battle_q   <= 1'b0;
            cursor_q      <= 3'd0;
            picked_mask_q <= {ROSTER_SIZE{1'b0}};
            pick_count_q  <= 2'd0;
            wins_q        <= 4'd0;
            losses_q      <= 4'd0;
        end else begin
            state_q       <= state_d;
            team_q        <= team_d;
            is_battle_q   <= is_battle_d;
            cursor_q      <= cursor_d;
            picked_mask_q <= picked_mask_d;
            pick_count_q  <= pick_count_d;
            wins_q        <= wins_d;
            losses_q      <= losses_d;
        end
    end

    assign team        = team_q;
    assign is_battle   = is_battle_q;
    assign cursor      = cursor_q;
    assign picked_mask = picked_mask_q;
    assign pick_count  = pick_count_q;
    assign wins        = wins_q;
    assign losses      = losses_q;

endmodule

// File: tb/tb_team_select.sv
// Directed self-checking bench for team_select; expectations follow the
// TEAM_SELECT_UNDO_EN setting of the build.
module tb_team_select;

    logic       Clk;
    logic       Reset;
    logic [7:0] keycode;
    logic       end_battle;
    logic       result;
    logic [5:0] team;
    logic       is_battle;
    logic [2:0] cursor;
    logic [7:0] picked_mask;
    logic [1:0] pick_count;
    logic [3:0] wins;
    logic [3:0] losses;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [7:0] K_W = 8'h1A;
    localparam logic [7:0] K_A = 8'h04;
    localparam logic [7:0] K_S = 8'h16;
    localparam logic [7:0] K_D = 8'h07;
    localparam logic [7:0] K_E = 8'h28;
    localparam logic [7:0] K_B = 8'h2A;

    team_select dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .end_battle  (end_battle),
        .result      (result),
        .team        (team),
        .is_battle   (is_battle),
        .cursor      (cursor),
        .picked_mask (picked_mask),
        .pick_count  (pick_count),
        .wins        (wins),
        .losses      (losses)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Press for one cycle, then release for one cycle.
    task automatic press(input logic [7:0] k);
        keycode = k;
        tick();
        keycode = 8'h00;
        tick();
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_team"}, 32'(team), 32'h0);
        chk({tag, "_isb"}, 32'(is_battle), 32'h0);
        chk({tag, "_cur"}, 32'(cursor), 32'h0);
        chk({tag, "_mask"}, 32'(picked_mask), 32'h0);
        chk({tag, "_cnt"}, 32'(pick_count), 32'h0);
        chk({tag, "_wins"}, 32'(wins), 32'h0);
        chk({tag, "_loss"}, 32'(losses), 32'h0);
    endtask

    initial begin
        Reset      = 1'b1;
        keycode    = 8'h00;
        end_battle = 1'b0;
        result     = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        chk_all_reset("reset");

        // Title -> Pick, then a held D moves the cursor once.
        press(K_E);
        keycode = K_D;
        tick();
        chk("hold_d_first", 32'(cursor), 32'd1);
        repeat (9) tick();
        chk("hold_d_held", 32'(cursor), 32'd1);
        keycode = 8'h00;
        tick();

        press(K_D);
        press(K_D);
        chk("cur_to_3", 32'(cursor), 32'd3);
        press(K_D);
        chk("d_sat_right", 32'(cursor), 32'd3);
        press(K_S);
        chk("s_down", 32'(cursor), 32'd7);
        press(K_S);
        chk("s_sat_bottom", 32'(cursor), 32'd7);

        // Pick 5, retry 5, then pick 2.
        press(K_A);
        press(K_A);
        chk("cur_to_5", 32'(cursor), 32'd5);
        press(K_E);
        chk("pick5_cnt", 32'(pick_count), 32'd1);
        chk("pick5_mask", 32'(picked_mask), 32'h20);
        chk("pick5_team", 32'(team), 32'h05);
        press(K_E);
        chk("dup_cnt", 32'(pick_count), 32'd1);
        chk("dup_mask", 32'(picked_mask), 32'h20);
        press(K_W);
        press(K_D);
        chk("cur_to_2", 32'(cursor), 32'd2);
        press(K_E);
        chk("pick2_team", 32'(team), 32'h15);
        chk("pick2_mask", 32'(picked_mask), 32'h24);
        chk("pick2_cnt", 32'(pick_count), 32'd2);

        // In Ready, movement keys are ignored.
        press(K_W);
        chk("ready_w_ignored", 32'(cursor), 32'd2);

        press(K_B);
`ifdef TEAM_SELECT_UNDO_EN
        chk("undo_cnt", 32'(pick_count), 32'd1);
        chk("undo_mask", 32'(picked_mask), 32'h20);
        chk("undo_team", 32'(team), 32'h05);
        press(K_E);
        chk("repick_team", 32'(team), 32'h15);
`else
        chk("bksp_cnt", 32'(pick_count), 32'd2);
        chk("bksp_mask", 32'(picked_mask), 32'h24);
`endif

        // Launch: is_battle rises two edges after the ENTER press.
        keycode = K_E;
        tick();
        chk("launch_isb0", 32'(is_battle), 32'h0);
        tick();
        chk("launch_isb1", 32'(is_battle), 32'h1);
        keycode = 8'h00;
        tick();
        press(K_W);
        press(K_E);
        chk("battle_team", 32'(team), 32'h15);
        chk("battle_cur", 32'(cursor), 32'd2);
        chk("battle_isb", 32'(is_battle), 32'h1);

        // Win, with an ENTER press landing on the same cycle as end_battle.
        end_battle = 1'b1;
        result     = 1'b1;
        keycode    = K_E;
        tick();
        end_battle = 1'b0;
        result     = 1'b0;
        chk("win_isb", 32'(is_battle), 32'h0);
        chk("win_wins", 32'(wins), 32'd1);
        chk("win_loss", 32'(losses), 32'd0);
        keycode = 8'h00;
        tick();
        chk("report_keeps_team", 32'(team), 32'h15);
        end_battle = 1'b1;
        result     = 1'b1;
        tick();
        end_battle = 1'b0;
        result     = 1'b0;
        tick();
        chk("stray_end_battle", 32'(wins), 32'd1);

        // Sixteen losses; counter saturates at 15.
        for (int i = 0; i < 16; i++) begin
            press(K_E);
            if (i == 0) begin
                chk("report_clear_cnt", 32'(pick_count), 32'd0);
                chk("report_clear_mask", 32'(picked_mask), 32'h0);
                chk("report_clear_team", 32'(team), 32'h0);
            end
            press(K_A);
            press(K_E);
            press(K_D);
            press(K_E);
            if (i == 0) begin
                chk("loop_team", 32'(team), 32'h11);
            end
            press(K_E);
            end_battle = 1'b1;
            tick();
            end_battle = 1'b0;
            if (i == 0) begin
                chk("loss_first", 32'(losses), 32'd1);
            end
        end
        chk("loss_sat", 32'(losses), 32'd15);
        chk("loss_wins", 32'(wins), 32'd1);

        // Reset while in battle.
        press(K_E);
        press(K_A);
        press(K_E);
        press(K_D);
        press(K_E);
        press(K_E);
        chk("pre_reset_isb", 32'(is_battle), 32'h1);
        Reset = 1'b1;
        tick();
        chk_all_reset("mid_reset");
        Reset = 1'b0;
        tick();

        // Pick 1 and 4, then BKSP from Ready.
        press(K_E);
        press(K_D);
        press(K_W);
        chk("w_sat_top", 32'(cursor), 32'd1);
        press(K_E);
        press(K_A);
        press(K_A);
        chk("a_sat_left", 32'(cursor), 32'd0);
        press(K_S);
        press(K_E);
        chk("p14_team", 32'(team), 32'h21);
        chk("p14_mask", 32'(picked_mask), 32'h12);
        press(K_B);
        press(K_D);
`ifdef TEAM_SELECT_UNDO_EN
        chk("undo14_cnt", 32'(pick_count), 32'd1);
        chk("undo14_mask", 32'(picked_mask), 32'h02);
        chk("undo14_in_pick", 32'(cursor), 32'd5);
`else
        chk("bksp14_cnt", 32'(pick_count), 32'd2);
        chk("bksp14_mask", 32'(picked_mask), 32'h12);
        chk("bksp14_in_ready", 32'(cursor), 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
